camera_sensor_emulator: RTL and testbench
=========================================

# camera_sensor_emulator

Parallel-interface camera sensor emulator. It drives 12-bit Bayer pixel data with frame-valid and line-valid strobes on CAMERA_PIXCLK, using the same framing the sensor capture path expects. It is used as a drop-in source in place of the physical camera for bring-up, the capture-path testbench and on-board self-test. The capture path measures exactly H_ACTIVE pixels per line and V_ACTIVE lines per frame from this source.

## Interface
- H_ACTIVE, 1920: active pixels per line (1..4095)
- H_BLANK, 64: LVAL-low pixel clocks between lines of a frame (≥1)
- V_ACTIVE, 1080: active lines per frame (1..4095)
- FV_SETUP, 4: clocks from FVAL rise to first LVAL rise (≥1)
- FV_HOLD, 4: clocks from last LVAL fall to FVAL fall (≥1)
- V_BLANK_CYC, 2048: FVAL-low clocks between frames (≥1)
- CAMERA_PIXCLK  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; level, sampled each clock
- pattern_sel  in  2  test pattern; latched at frame start
- CAMERA_D  out  12  pixel data, registered
- CAMERA_FVAL  out  1  frame valid, registered
- CAMERA_LVAL  out  1  line valid, registered
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset is asynchronous and active-low. The reset value of every output is 0 (CAMERA_D, CAMERA_FVAL, CAMERA_LVAL, frame_count, busy). State returns to IDLE; x and y counters clear.
- States: IDLE, SETUP, ACTIVE, HBLANK, HOLD, VBLANK.
- IDLE: FVAL=0, LVAL=0. When enable=1 → SETUP, latch pattern_sel, y=0.
- SETUP: FVAL=1, LVAL=0 for FV_SETUP clocks, then → ACTIVE with x=0.
- ACTIVE: FVAL=1, LVAL=1 for H_ACTIVE clocks; x runs 0..H_ACTIVE-1.
  - At x=H_ACTIVE-1: if y=V_ACTIVE-1 → HOLD; otherwise → HBLANK.
- HBLANK: LVAL=0 for H_BLANK clocks, y increments, then → ACTIVE.
- HOLD: FVAL=1, LVAL=0 for FV_HOLD clocks, then → VBLANK. FVAL falls, and frame_count increments on the same edge FVAL falls.
- VBLANK: FVAL=0 for V_BLANK_CYC clocks, then → SETUP if enable=1, else → IDLE.
- Deasserting enable mid-frame has no effect until the end of VBLANK. A frame is never truncated.
- pattern_sel changes mid-frame are ignored until the next SETUP entry.
- CAMERA_D=0 whenever LVAL=0. With LVAL=1 the value depends on the latched pattern:
  - 0: x[11:0] (horizontal ramp)
  - 1: y[11:0] (vertical ramp)
  - 2: (x[0]^y[0]) ? 12'hFFF : 12'h000 (Bayer checker)
  - 3: (x + y + frame_count[11:0]) mod 4096 (moving diagonal)
- All additions are 12-bit and truncating.

## Timing
- Outputs are registered. In any state the outputs reflect that state's values on the first clock after the transition edge.
- Start latency: if enable is first sampled high at edge N while IDLE, FVAL=1 after edge N+1.
- First LVAL rises FV_SETUP clocks after FVAL rises.
- Each line: LVAL high for exactly H_ACTIVE consecutive clocks.
- Inter-line gap: exactly H_BLANK clocks.
- CAMERA_D changes on the same edge as LVAL and pixel position. The pixel at x=k is present in the k-th LVAL-high clock.
- Frame period: FV_SETUP + V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + FV_HOLD + V_BLANK_CYC.
- Back-to-back frames run when enable stays high, with no extra idle clock between VBLANK and SETUP.
- Reset asserted mid-line forces FVAL, LVAL and D to 0 immediately (asynchronous). After release, the block restarts from IDLE.
- frame_count wrap-around: 0xFFFF + 1 = 0x0000, with no flag.

## Test plan
Unless noted, all scenarios use H_ACTIVE=8, H_BLANK=3, V_ACTIVE=4, FV_SETUP=2, FV_HOLD=2, V_BLANK_CYC=5.
- Reset, then enable=1 and pattern_sel=0 → FVAL rises 1 clock later. LVAL rises 2 clocks after that. D shows 0,1..7 per line. There are 4 LVAL pulses of 8 clocks with 3-clock gaps. FVAL falls 2 clocks after the last LVAL. frame_count=1. The next FVAL rises 5 clocks later (period 50).
- pattern_sel=2 for one frame → per line, D = {000,FFF,000,FFF,...} on even y and {FFF,000,...} on odd y. D=0 whenever LVAL=0.
- Toggle pattern_sel 0→1 mid-frame → the current frame keeps the ramp. The next frame D equals y (0..3) across each whole line.
- Drop enable during line 1 → the frame completes with all 4 lines. After VBLANK the block goes IDLE with busy=0 and FVAL stays low. Re-raising enable restarts the frame.
- Assert reset_n=0 mid-ACTIVE → FVAL, LVAL, D and frame_count are 0 without waiting for a clock edge. After release with enable=1, a complete frame follows.
- Force frame_count to 0xFFFE with pattern_sel=3 → two frames later frame_count=0x0000. Pattern 3 data at (x=0,y=0) equals frame_count[11:0] latched in that frame.

Source files
------------

// File: rtl/camera_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : camera_sensor_emulator
// Purpose  : Parallel-interface camera sensor emulator. Generates 12-bit
//            Bayer-style test pixels framed by FVAL/LVAL strobes. It can
//            stand in for the physical sensor on the capture path.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CAMERA_PIXCLK  in   1   pixel clock, all logic on rising edge
//   reset_n        in   1   asynchronous, active-low reset
//   enable         in   1   run request (level), checked in IDLE/end of VBLANK
//   pattern_sel    in   2   test pattern, latched when a frame starts
//   CAMERA_D       out  12  pixel data (0 while LVAL is low)
//   CAMERA_FVAL    out  1   frame valid
//   CAMERA_LVAL    out  1   line valid
//   frame_count    out  16  completed frames, free-running wrap
//   busy           out  1   high whenever the sequencer is not IDLE
// ============================================================================
module camera_sensor_emulator #(
  parameter int H_ACTIVE    = 1920,
  parameter int H_BLANK     = 64,
  parameter int V_ACTIVE    = 1080,
  parameter int FV_SETUP    = 4,
  parameter int FV_HOLD     = 4,
  parameter int V_BLANK_CYC = 2048
) (
  input  logic        CAMERA_PIXCLK,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [11:0] CAMERA_D,
  output logic        CAMERA_FVAL,
  output logic        CAMERA_LVAL,
  output logic [15:0] frame_count,
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Dwell counter sizing: one counter serves SETUP, HBLANK, HOLD and VBLANK,
  // so it has to hold the largest of their terminal counts.
  // --------------------------------------------------------------------------
  localparam int c_MAX_A   = (H_BLANK  > FV_SETUP)    ? H_BLANK  : FV_SETUP;
  localparam int c_MAX_B   = (FV_HOLD  > V_BLANK_CYC) ? FV_HOLD  : V_BLANK_CYC;
  localparam int c_CNT_MAX = ((c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B) - 1;
  localparam int c_CNT_W   = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LAST  = c_CNT_W'(FV_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HBLANK_LAST = c_CNT_W'(H_BLANK - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(FV_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_VBLANK_LAST = c_CNT_W'(V_BLANK_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  localparam logic [11:0] c_X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] c_Y_LAST = 12'(V_ACTIVE - 1);

  // Sequencer states
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SETUP  = 3'd1;
  localparam logic [2:0] c_ST_ACTIVE = 3'd2;
  localparam logic [2:0] c_ST_HBLANK = 3'd3;
  localparam logic [2:0] c_ST_HOLD   = 3'd4;
  localparam logic [2:0] c_ST_VBLANK = 3'd5;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [11:0]        r_x;
  logic [11:0]        r_y;
  logic [1:0]         r_pat;
  logic [15:0]        r_frame_count;
  logic [11:0]        r_d;
  logic               r_fval;
  logic               r_lval;

  // Next-state wires
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [11:0]        w_x_nxt;
  logic [11:0]        w_y_nxt;
  logic [1:0]         w_pat_nxt;

  // Output-decode wires
  logic [11:0]        w_pix_sum;
  logic [11:0]        w_pixel;
  logic               w_fval;
  logic               w_lval;
  logic               w_frame_done;

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_pat_nxt   = r_pat;

    case (r_state)
      c_ST_IDLE: begin
        if (enable) begin
          w_state_nxt = c_ST_SETUP;
          w_cnt_nxt   = '0;
          w_y_nxt     = 12'd0;
          w_pat_nxt   = pattern_sel;
        end
      end

      c_ST_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_state_nxt = c_ST_ACTIVE;
          w_cnt_nxt   = '0;
          w_x_nxt     = 12'd0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end

      c_ST_ACTIVE: begin
        if (r_x == c_X_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_y == c_Y_LAST) ? c_ST_HOLD : c_ST_HBLANK;
        end else begin
          w_x_nxt     = r_x + 12'd1;
        end
      end

      c_ST_HBLANK: begin
        if (r_cnt == c_HBLANK_LAST) begin
          w_state_nxt = c_ST_ACTIVE;
          w_cnt_nxt   = '0;
          w_x_nxt     = 12'd0;
          w_y_nxt     = r_y + 12'd1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end

      c_ST_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = c_ST_VBLANK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end

      c_ST_VBLANK: begin
        // enable is only honoured here, so a running frame always completes.
        if (r_cnt == c_VBLANK_LAST) begin
          w_cnt_nxt = '0;
          if (enable) begin
            w_state_nxt = c_ST_SETUP;
            w_y_nxt     = 12'd0;
            w_pat_nxt   = pattern_sel;
          end else begin
            w_state_nxt = c_ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_x     <= 12'd0;
      r_y     <= 12'd0;
      r_pat   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel generator, decoded from the current position.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pix_sum = r_x + r_y + r_frame_count[11:0];
    case (r_pat)
      2'd0:    w_pixel = r_x;
      2'd1:    w_pixel = r_y;
      2'd2:    w_pixel = (r_x[0] ^ r_y[0]) ? 12'hFFF : 12'h000;
      default: w_pixel = w_pix_sum;
    endcase
  end

  assign w_fval = (r_state == c_ST_SETUP)  || (r_state == c_ST_ACTIVE) ||
                  (r_state == c_ST_HBLANK) || (r_state == c_ST_HOLD);
  assign w_lval = (r_state == c_ST_ACTIVE);

  // The strobes trail the state register by one clock. The first VBLANK clock
  // with FVAL still high is therefore the edge on which FVAL drops. The frame
  // counter advances on that same edge.
  assign w_frame_done = (r_state == c_ST_VBLANK) && r_fval;

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_d           <= 12'd0;
      r_fval        <= 1'b0;
      r_lval        <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_fval <= w_fval;
      r_lval <= w_lval;
      r_d    <= w_lval ? w_pixel : 12'd0;
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign CAMERA_D    = r_d;
  assign CAMERA_FVAL = r_fval;
  assign CAMERA_LVAL = r_lval;
  assign frame_count = r_frame_count;
  assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_camera_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_sensor_emulator
// Purpose  : Self-checking bench for camera_sensor_emulator. It uses small
//            geometry: 8x4 active, H blank 3, setup 2, hold 2, V blank 5.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Frame timeline, with k = clocks since the edge that enters SETUP (k=0):
//   FVAL high k=1..45, line y LVAL high k=3+11y .. 10+11y,
//   frame_count steps at k=46, next frame's k=0 is this frame's k=50.
// ============================================================================
module tb_camera_sensor_emulator;

  localparam int PERIOD = 50;   // 2 + 4*8 + 3*3 + 2 + 5
  localparam int LINE   = 11;   // 8 active + 3 blank

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] CAMERA_D;
  logic        CAMERA_FVAL;
  logic        CAMERA_LVAL;
  logic [15:0] frame_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  camera_sensor_emulator #(
    .H_ACTIVE   (8),
    .H_BLANK    (3),
    .V_ACTIVE   (4),
    .FV_SETUP   (2),
    .FV_HOLD    (2),
    .V_BLANK_CYC(5)
  ) dut (
    .CAMERA_PIXCLK(clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pattern_sel  (pattern_sel),
    .CAMERA_D     (CAMERA_D),
    .CAMERA_FVAL  (CAMERA_FVAL),
    .CAMERA_LVAL  (CAMERA_LVAL),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-level stimulus record. chg_* are inputs applied at clock chg_k of the
  // frame. pat/fc are the expected latched pattern and frame count.
  typedef struct {
    logic [1:0]  pat;
    logic [15:0] fc;
    int          chg_k;
    logic [1:0]  chg_psel;
    logic        chg_en;
    string       tag;
  } frame_vec_t;

  frame_vec_t vecs [4];

  function automatic logic [30:0] observed();
    return {busy, CAMERA_FVAL, CAMERA_LVAL, CAMERA_D, frame_count};
  endfunction

  // Expected {busy, fval, lval, d, frame_count} at clock k of a frame.
  function automatic logic [30:0] exp_at(int k, logic [1:0] pat, logic [15:0] fc);
    logic        fv;
    logic        lv;
    logic [11:0] d;
    logic [11:0] x12;
    logic [11:0] y12;
    logic [15:0] f;
    int          t;
    fv = (k >= 1) && (k <= 45);
    lv = 1'b0;
    d  = 12'd0;
    t  = k - 3;
    if (t >= 0 && (t / LINE) < 4 && (t % LINE) < 8) begin
      lv  = 1'b1;
      x12 = 12'(t % LINE);
      y12 = 12'(t / LINE);
      case (pat)
        2'd0:    d = x12;
        2'd1:    d = y12;
        2'd2:    d = (x12[0] ^ y12[0]) ? 12'hFFF : 12'h000;
        default: d = x12 + y12 + fc[11:0];
      endcase
    end
    f = (k >= 46) ? fc + 16'd1 : fc;
    return {1'b1, fv, lv, d, f};
  endfunction

  task automatic check(input string name, input int k, input logic [30:0] act,
                       input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got busy/fv/lv/d/fc=%b/%b/%b/%h/%h exp %b/%b/%b/%h/%h",
               name, k, act[30], act[29], act[28], act[27:16], act[15:0],
               exp[30], exp[29], exp[28], exp[27:16], exp[15:0]);
    end
  endtask

  // Walks one frame, k=0..PERIOD-1. Call it with k=0 as the next posedge.
  // It returns at the negedge of k=PERIOD-1.
  task automatic run_frame(input logic [1:0] pat, input logic [15:0] fc,
                           input int chg_k, input logic [1:0] chg_psel,
                           input logic chg_en, input string tag);
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      check(tag, k, observed(), exp_at(k, pat, fc));
      if (k == chg_k) begin
        pattern_sel = chg_psel;
        enable      = chg_en;
      end
    end
  endtask

  initial begin
    vecs[0] = '{pat: 2'd0, fc: 16'd0, chg_k: 20, chg_psel: 2'd2, chg_en: 1'b1, tag: "ramp_x"};
    vecs[1] = '{pat: 2'd2, fc: 16'd1, chg_k: 30, chg_psel: 2'd0, chg_en: 1'b1, tag: "checker"};
    vecs[2] = '{pat: 2'd0, fc: 16'd2, chg_k: 25, chg_psel: 2'd1, chg_en: 1'b1, tag: "psel_midframe"};
    vecs[3] = '{pat: 2'd1, fc: 16'd3, chg_k: 17, chg_psel: 2'd1, chg_en: 1'b0, tag: "ramp_y_drop_en"};

    reset_n     = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    #1 reset_n = 1'b0;
    #1 check("reset_state", -1, observed(), 31'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with enable low: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle", i, observed(), 31'd0);
    end

    // Back-to-back frames, pattern changes, enable dropped in line 1 of the last.
    enable = 1'b1;
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].pat, vecs[v].fc, vecs[v].chg_k, vecs[v].chg_psel,
                vecs[v].chg_en, vecs[v].tag);
    end

    // The frame completed and the block dropped to IDLE.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_drop", i, observed(), {15'd0, 16'd4});
    end

    // Re-raise enable with the moving diagonal.
    enable      = 1'b1;
    pattern_sel = 2'd3;
    run_frame(2'd3, 16'd4, -1, 2'd0, 1'b1, "diag_restart");

    // Go into the next frame and assert reset while LVAL is high.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("pre_reset", k, observed(), exp_at(k, 2'd3, 16'd5));
    end
    #2 reset_n = 1'b0;
    #1 check("async_reset", 5, observed(), 31'd0);
    @(negedge clk);
    @(negedge clk);
    check("in_reset", 0, observed(), 31'd0);
    reset_n = 1'b1;
    run_frame(2'd3, 16'd0, -1, 2'd0, 1'b1, "after_reset");

    // Jump the frame counter near its wrap point. This is the VBLANK tail, where
    // the counter is stable.
    force dut.r_frame_count = 16'hFFFE;
    #1 release dut.r_frame_count;
    run_frame(2'd3, 16'hFFFE, -1, 2'd0, 1'b1, "diag_fffe");
    run_frame(2'd3, 16'hFFFF, -1, 2'd0, 1'b1, "diag_wrap");
    check("wrap_zero", 0, {15'd0, frame_count}, 31'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
